// File: rtl/sd_cmd_tx.sv
// sd_cmd_tx: serial SD command transmitter.
// Builds {start, tx, index, arg, CRC7, end} and shifts it MSB-first onto CMD,
// then holds the line idle-high for NCC bit periods before pulsing done.
// CRC7 (x^7 + x^3 + 1) is accumulated bit-serially over the first 40 bits.
module sd_cmd_tx #(
  parameter int CLK_DIV = 2,  // clk cycles per CMD bit period, 1..255
  parameter int NCC     = 8   // idle-high bit periods after the end bit, 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        bit_tick,
  output logic        busy,
  output logic        done,
  output logic [6:0]  crc_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CRC,
    S_END,
    S_GAP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] DIV_PEN  = 8'(CLK_DIV - 2);
  localparam logic [5:0] NCC_LAST = 6'(NCC - 1);
  localparam logic [5:0] NCC_PEN  = 6'(NCC - 2);

  state_t      r_state;
  logic [7:0]  r_div;
  logic [5:0]  r_bit;
  logic [39:0] r_frame;
  logic [6:0]  r_crc;
  logic [6:0]  r_crc_out;
  logic        r_cmd_out;
  logic        r_cmd_oe;
  logic        r_bit_tick;
  logic        r_busy;
  logic        r_done;

  logic       w_period_end;
  logic       w_fb;
  logic [6:0] w_crc_upd;
  logic       w_done_next;

  assign w_period_end = (r_div == DIV_LAST);
  assign w_fb         = r_frame[39] ^ r_crc[6];
  assign w_crc_upd    = {r_crc[5:3], r_crc[2] ^ w_fb, r_crc[1:0], w_fb};

  // done is registered, so it is raised on the edge that enters the very
  // last clk of the gap. With one clk per bit that clk is a whole period,
  // so the lookahead moves back one bit (or into END when the gap is 1 bit).
  assign w_done_next = (CLK_DIV == 1) ?
                         ((NCC == 1) ? (r_state == S_END)
                                     : (r_state == S_GAP && r_bit == NCC_PEN)) :
                         (r_state == S_GAP && r_bit == NCC_LAST && r_div == DIV_PEN);

  assign cmd_out  = r_cmd_out;
  assign cmd_oe   = r_cmd_oe;
  assign bit_tick = r_bit_tick;
  assign busy     = r_busy;
  assign done     = r_done;
  assign crc_out  = r_crc_out;

  // Frame FSM: every output is set on the edge that begins the clk it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_div      <= 8'd0;
      r_bit      <= 6'd0;
      r_frame    <= 40'd0;
      r_crc      <= 7'd0;
      r_crc_out  <= 7'd0;
      r_cmd_out  <= 1'b1;
      r_cmd_oe   <= 1'b0;
      r_bit_tick <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_div  <= 8'd0;
          r_bit  <= 6'd0;
          if (start) begin
            r_state    <= S_SHIFT;
            r_frame    <= {2'b01, cmd_index, cmd_arg};
            r_crc      <= 7'd0;
            r_cmd_out  <= 1'b0;  // start bit
            r_cmd_oe   <= 1'b1;
            r_bit_tick <= 1'b1;
            r_busy     <= 1'b1;
          end else begin
            r_cmd_out  <= 1'b1;
            r_cmd_oe   <= 1'b0;
            r_bit_tick <= 1'b0;
            r_busy     <= 1'b0;
          end
        end
        default: begin
          r_done <= w_done_next;
          if (!w_period_end) begin
            r_div      <= r_div + 8'd1;
            r_bit_tick <= 1'b0;
          end else begin
            r_div      <= 8'd0;
            r_bit_tick <= 1'b1;
            case (r_state)
              S_SHIFT: begin
                r_crc   <= w_crc_upd;
                r_frame <= {r_frame[38:0], 1'b0};
                if (r_bit == 6'd39) begin
                  r_state   <= S_CRC;
                  r_bit     <= 6'd0;
                  r_crc_out <= w_crc_upd;
                  r_cmd_out <= w_crc_upd[6];
                end else begin
                  r_bit     <= r_bit + 6'd1;
                  r_cmd_out <= r_frame[38];
                end
              end
              S_CRC: begin
                r_crc <= {r_crc[5:0], 1'b0};
                if (r_bit == 6'd6) begin
                  r_state   <= S_END;
                  r_bit     <= 6'd0;
                  r_cmd_out <= 1'b1;  // end bit
                end else begin
                  r_bit     <= r_bit + 6'd1;
                  r_cmd_out <= r_crc[5];
                end
              end
              S_END: begin
                r_state   <= S_GAP;
                r_bit     <= 6'd0;
                r_cmd_oe  <= 1'b0;
                r_cmd_out <= 1'b1;
              end
              S_GAP: begin
                if (r_bit == NCC_LAST) begin
                  r_state    <= S_IDLE;
                  r_bit      <= 6'd0;
                  r_bit_tick <= 1'b0;
                  r_busy     <= 1'b0;
                end else begin
                  r_bit <= r_bit + 6'd1;
                end
              end
              default: begin
                r_state <= S_IDLE;
                r_bit   <= 6'd0;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Testbench for sd_cmd_tx: three instances (CLK_DIV = 2, 1, 3) checked against
// a polynomial-division CRC7 model and timing rules derived from the bit map.
module tb_sd_cmd_tx;

  localparam int NCC = 8;
  localparam logic [23:0] DIVS = {8'd3, 8'd1, 8'd2};  // unit 0:2, unit 1:1, unit 2:3

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_s [3];
  logic [5:0]  idx_s   [3];
  logic [31:0] arg_s   [3];
  logic        out_s   [3];
  logic        oe_s    [3];
  logic        tick_s  [3];
  logic        busy_s  [3];
  logic        done_s  [3];
  logic [6:0]  crc_s   [3];
  logic [6:0]  last_crc[3];

  int n_checks = 0;
  int n_fail   = 0;

  bit rec_oe [160];
  bit rec_out[160];
  bit rec_tick[160];
  bit rec_busy[160];
  bit rec_done[160];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      sd_cmd_tx #(
        .CLK_DIV(int'(DIVS[gi*8 +: 8])),
        .NCC    (NCC)
      ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_s[gi]),
        .cmd_index(idx_s[gi]),
        .cmd_arg  (arg_s[gi]),
        .cmd_out  (out_s[gi]),
        .cmd_oe   (oe_s[gi]),
        .bit_tick (tick_s[gi]),
        .busy     (busy_s[gi]),
        .done     (done_s[gi]),
        .crc_out  (crc_s[gi])
      );
    end
  endgenerate

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [47:0] frame;
    logic [6:0]  crc;
  } vec_t;

  vec_t tbl[4];

  function automatic int div_of(input int u);
    return int'(DIVS[u*8 +: 8]);
  endfunction

  // CRC7 as the remainder of msg * x^7 divided by x^7 + x^3 + 1
  function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'd0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One complete frame on unit u, observing every clk from E0+1 to one past done.
  task automatic run_frame(input int u, input logic [5:0] idx, input logic [31:0] arg,
                           input logic [47:0] want_frame, input logic [6:0] want_crc,
                           input int disturb_at, input string tag);
    int d, total, k, ph;
    int oe_cnt, tick_cnt, tick_pos_err, hold_err, busy_cnt, done_cnt, done_at, idle_err;
    logic [47:0] got;
    logic [6:0]  crc_first;
    d = div_of(u);
    total = (48 + NCC) * d;
    oe_cnt = 0; tick_cnt = 0; tick_pos_err = 0; hold_err = 0;
    busy_cnt = 0; done_cnt = 0; done_at = -1; idle_err = 0;
    got = '1;
    crc_first = 7'h00;
    @(negedge clk);
    start_s[u] = 1'b1;
    idx_s[u]   = idx;
    arg_s[u]   = arg;
    @(posedge clk);
    for (int c = 1; c <= total + 1; c++) begin
      @(negedge clk);
      k  = (c - 1) / d;
      ph = (c - 1) % d;
      if (c == 1) chk({tag, " crc_out held from previous frame"}, crc_s[u], last_crc[u]);
      if (oe_s[u]) oe_cnt++;
      if (c <= 48 * d) begin
        if (ph == 0) got[47-k] = out_s[u];
        else if (out_s[u] !== got[47-k]) hold_err++;
      end else if (oe_s[u] !== 1'b0 || out_s[u] !== 1'b1) begin
        idle_err++;
      end
      if (tick_s[u]) begin
        tick_cnt++;
        if (ph != 0 || c > total) tick_pos_err++;
      end
      if (busy_s[u]) busy_cnt++;
      if (done_s[u]) begin
        done_cnt++;
        done_at = c;
      end
      if (c == 40 * d + 1) crc_first = crc_s[u];
      if (c == 1) start_s[u] = 1'b0;
      if (c == disturb_at) begin
        start_s[u] = 1'b1;
        idx_s[u]   = 6'd17;
        arg_s[u]   = ~arg;
      end
      if (c == disturb_at + 1) start_s[u] = 1'b0;
    end
    chk({tag, " serial frame"}, got, want_frame);
    chk({tag, " cmd_oe clks"}, oe_cnt, 48 * d);
    chk({tag, " bit held whole period"}, hold_err, 0);
    chk({tag, " idle line after end bit"}, idle_err, 0);
    chk({tag, " bit_tick pulses"}, tick_cnt, 48 + NCC);
    chk({tag, " bit_tick misplaced"}, tick_pos_err, 0);
    chk({tag, " busy clks"}, busy_cnt, total);
    chk({tag, " done pulses"}, done_cnt, 1);
    chk({tag, " done clk"}, done_at, total);
    chk({tag, " crc_out at CRC start"}, crc_first, want_crc);
    chk({tag, " crc_out after frame"}, crc_s[u], want_crc);
    last_crc[u] = want_crc;
    $display("frame %s unit %0d div %0d: sent %012h want %012h crc %02h", tag, u, d, got,
             want_frame, crc_s[u]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  r_idx;
    logic [31:0] r_arg;
    logic [6:0]  r_crc;
    logic [47:0] b1, b2;
    int u, dn, f1, run1, gap, gap_bad, f2, run2, tick_miss, busy_cnt, done_cnt, busy_seen;

    tbl[0] = '{idx: 6'd0,  arg: 32'h0000_0000, frame: 48'h40_00_00_00_00_95, crc: 7'h4A};
    tbl[1] = '{idx: 6'd8,  arg: 32'h0000_01AA, frame: 48'h48_00_00_01_AA_87, crc: 7'h43};
    tbl[2] = '{idx: 6'd55, arg: 32'h0000_0000, frame: 48'h77_00_00_00_00_65, crc: 7'h32};
    tbl[3] = '{idx: 6'd41, arg: 32'h4000_0000, frame: 48'h69_40_00_00_00_77, crc: 7'h3B};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_s[i]  = 1'b0;
      idx_s[i]    = 6'd0;
      arg_s[i]    = 32'd0;
      last_crc[i] = 7'h00;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset u%0d cmd_out", i), out_s[i], 1'b1);
      chk($sformatf("reset u%0d cmd_oe", i), oe_s[i], 1'b0);
      chk($sformatf("reset u%0d bit_tick", i), tick_s[i], 1'b0);
      chk($sformatf("reset u%0d busy", i), busy_s[i], 1'b0);
      chk($sformatf("reset u%0d done", i), done_s[i], 1'b0);
      chk($sformatf("reset u%0d crc_out", i), crc_s[i], 7'h00);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Known SD commands on CLK_DIV=2
    for (int i = 0; i < 4; i++)
      run_frame(0, tbl[i].idx, tbl[i].arg, tbl[i].frame, tbl[i].crc, 0,
                $sformatf("table%0d", i));

    // Random commands against the division model, alternating CLK_DIV=2 and 3
    for (int i = 0; i < 6; i++) begin
      u = (i % 2 == 0) ? 0 : 2;
      r_idx = 6'($urandom_range(0, 63));
      r_arg = $urandom;
      r_crc = crc7_ref({2'b01, r_idx, r_arg});
      run_frame(u, r_idx, r_arg, {2'b01, r_idx, r_arg, r_crc, 1'b1}, r_crc, 0,
                $sformatf("rand%0d", i));
    end

    // CLK_DIV=3 corner: 144 driven clks, 56 ticks
    run_frame(2, tbl[0].idx, tbl[0].arg, tbl[0].frame, tbl[0].crc, 0, "div3_cmd0");

    // start pulse with index 17 and a new argument mid-frame must be ignored
    run_frame(0, tbl[1].idx, tbl[1].arg, tbl[1].frame, tbl[1].crc, 30, "ignored_start");
    busy_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy_s[0]) busy_seen++;
    end
    chk("ignored_start no second frame", busy_seen, 0);

    // Back-to-back on CLK_DIV=1 with start held high; args switched when done is seen
    @(negedge clk);
    start_s[1] = 1'b1;
    idx_s[1]   = 6'd0;
    arg_s[1]   = 32'd0;
    dn = 0;
    for (int c = 1; c < 160; c++) begin
      @(negedge clk);
      rec_oe[c]   = oe_s[1];
      rec_out[c]  = out_s[1];
      rec_tick[c] = tick_s[1];
      rec_busy[c] = busy_s[1];
      rec_done[c] = done_s[1];
      if (done_s[1]) begin
        dn++;
        if (dn == 1) begin
          idx_s[1] = 6'd8;
          arg_s[1] = 32'h0000_01AA;
        end else begin
          start_s[1] = 1'b0;
        end
      end
    end
    start_s[1] = 1'b0;
    f1 = 1;
    while (f1 < 159 && !rec_oe[f1]) f1++;
    chk("b2b first drive clk", f1, 1);
    run1 = 0;
    while (f1 + run1 < 160 && rec_oe[f1 + run1]) run1++;
    b1 = '1;
    for (int k = 0; k < 48; k++) if (f1 + k < 160) b1[47-k] = rec_out[f1 + k];
    gap = 0;
    gap_bad = 0;
    while (f1 + run1 + gap < 160 && !rec_oe[f1 + run1 + gap]) begin
      if (!rec_out[f1 + run1 + gap]) gap_bad++;
      gap++;
    end
    f2 = f1 + run1 + gap;
    run2 = 0;
    while (f2 + run2 < 160 && rec_oe[f2 + run2]) run2++;
    b2 = '1;
    for (int k = 0; k < 48; k++) if (f2 + k < 160) b2[47-k] = rec_out[f2 + k];
    tick_miss = 0;
    busy_cnt  = 0;
    done_cnt  = 0;
    for (int c = 1; c < 160; c++) begin
      if (rec_busy[c]) busy_cnt++;
      if (rec_busy[c] && !rec_tick[c]) tick_miss++;
      if (rec_done[c]) done_cnt++;
    end
    chk("b2b frame1 driven clks", run1, 48);
    chk("b2b frame1 bits", b1, tbl[0].frame);
    // NCC gap clks plus the single IDLE clk in which the held start is resampled
    chk("b2b undriven clks between frames", gap, NCC + 1);
    chk("b2b gap line low", gap_bad, 0);
    chk("b2b frame2 driven clks", run2, 48);
    chk("b2b frame2 bits", b2, tbl[1].frame);
    chk("b2b done pulses", done_cnt, 2);
    chk("b2b busy clks", busy_cnt, 2 * (48 + NCC));
    chk("b2b bit_tick on busy clks", tick_miss, 0);
    chk("b2b crc_out", crc_s[1], tbl[1].crc);
    $display("frame b2b unit 1 div 1: sent %012h then %012h gap %0d", b1, b2, gap);
    last_crc[1] = tbl[1].crc;

    // Reset in the middle of bit 20 of CMD0 on CLK_DIV=2
    @(negedge clk);
    start_s[0] = 1'b1;
    idx_s[0]   = 6'd0;
    arg_s[0]   = 32'd0;
    @(posedge clk);
    for (int c = 1; c <= 41; c++) begin
      @(negedge clk);
      if (c == 1) start_s[0] = 1'b0;
    end
    chk("midreset busy before reset", busy_s[0], 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset cmd_oe", oe_s[0], 1'b0);
    chk("midreset cmd_out", out_s[0], 1'b1);
    chk("midreset busy", busy_s[0], 1'b0);
    chk("midreset crc_out", crc_s[0], 7'h00);
    chk("midreset done", done_s[0], 1'b0);
    chk("midreset bit_tick", tick_s[0], 1'b0);
    dn = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done_s[0] || busy_s[0]) dn++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done_s[0] || busy_s[0]) dn++;
    end
    chk("midreset no done or busy after reset", dn, 0);
    $display("reset at bit 20 of CMD0 on unit 0");
    for (int i = 0; i < 3; i++) last_crc[i] = 7'h00;
    run_frame(0, tbl[0].idx, tbl[0].arg, tbl[0].frame, tbl[0].crc, 0, "after_reset_cmd0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
